// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the pairwise adder, psum_accumulator and the
// activation/pooling stage: a valid/ready input channel carrying signed
// partial sums and a valid/ready output channel carrying saturated results.
interface psum_accumulator_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    // Producer/consumer side, i.e. whatever surrounds the accumulator
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat,
        output out_ready
    );

    // Accumulator side
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat,
        input  out_ready
    );
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums TAPS signed partial sums into one convolution output,
// saturates it to OUT_W bits and holds it on a valid/ready output until taken.
// Optional macro PSUM_RELU_EN fuses a ReLU after saturation (negative -> 0,
// out_sat cleared for that result).
module psum_accumulator #(
    parameter int IN_W  = 16,
    parameter int TAPS  = 3,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    psum_accumulator_if.slave    bus,
    output logic [7:0]           tap_cnt
);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [7:0]              LAST_TAP = 8'(TAPS - 1);

    // Clamp a full-width total into OUT_W bits; MSB of the result is the clip flag
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] total);
        logic [OUT_W:0] res;
        if (total > SAT_MAX) begin
            res = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (total < SAT_MIN) begin
            res = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            res = {1'b0, total[OUT_W-1:0]};
        end
`ifdef PSUM_RELU_EN
        if (res[OUT_W-1]) begin
            res = '0;
        end else begin
            res = res;
        end
`endif
        return res;
    endfunction

    state_t                   state_r, state_s;
    logic signed [ACC_W-1:0]  acc_r, acc_s;
    logic [7:0]               tap_cnt_r, tap_cnt_s;
    logic                     out_valid_r, out_valid_s;
    logic [OUT_W-1:0]         out_data_r, out_data_s;
    logic                     out_sat_r, out_sat_s;

    logic                     accept_s;
    logic signed [ACC_W-1:0]  ext_s;
    logic signed [ACC_W-1:0]  sum_s;
    logic [OUT_W:0]           sat_s;

    assign accept_s = bus.in_valid && (state_r == ST_ACC);
    assign ext_s    = {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign sum_s    = acc_r + ext_s;
    assign sat_s    = saturate(sum_s);

    assign bus.in_ready  = (state_r == ST_ACC);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sat   = out_sat_r;
    assign tap_cnt       = tap_cnt_r;

    // Next-state and datapath update; clr overrides everything else
    always_comb begin
        state_s     = state_r;
        acc_s       = acc_r;
        tap_cnt_s   = tap_cnt_r;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;
        out_sat_s   = out_sat_r;
        if (clr) begin
            state_s     = ST_ACC;
            acc_s       = '0;
            tap_cnt_s   = 8'd0;
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        if (tap_cnt_r == LAST_TAP) begin
                            out_data_s  = sat_s[OUT_W-1:0];
                            out_sat_s   = sat_s[OUT_W];
                            out_valid_s = 1'b1;
                            acc_s       = '0;
                            tap_cnt_s   = 8'd0;
                            state_s     = ST_HOLD;
                        end else begin
                            acc_s     = sum_s;
                            tap_cnt_s = tap_cnt_r + 8'd1;
                        end
                    end else begin
                        state_s = ST_ACC;
                    end
                end
                ST_HOLD: begin
                    // Input is not taken in the handshake cycle; ACC resumes next cycle
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_s = 1'b0;
                        state_s     = ST_ACC;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s     = ST_ACC;
                    acc_s       = '0;
                    tap_cnt_s   = 8'd0;
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_ACC;
            acc_r       <= '0;
            tap_cnt_r   <= 8'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_sat_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            tap_cnt_r   <= tap_cnt_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            out_sat_r   <= out_sat_s;
        end
    end

endmodule
